multu_hilo: RTL and testbench

MULTU_HILO -- requirements
Module: multu_hilo

---
 rtl/multu_hilo_pkg.sv | 21 ++
 rtl/hilo_reg.sv | 38 +++
 rtl/multu_hilo.sv | 98 +++++++++
 tb/tb_multu_hilo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/multu_hilo_pkg.sv
// Shared command codes, read-select encodings and FSM state type for the
// sequential unsigned multiplier with its HiLo result pair.
package multu_hilo_pkg;

  localparam logic [5:0] SIG_MULTU    = 6'd25;
  localparam logic [5:0] SIG_OPENHILO = 6'd63;

  // funct codes of the instructions that read the pair
  localparam logic [5:0] MFHI = 6'd16;
  localparam logic [5:0] MFLO = 6'd18;

  localparam logic [1:0] SEL_HI = 2'b01;
  localparam logic [1:0] SEL_LO = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_reg.sv
// Hi/Lo architectural register pair: single write port, combinational read mux.
module hilo_reg
  import multu_hilo_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic [1:0]  sel,
  output logic [31:0] data_out
);

  logic [31:0] hi;
  logic [31:0] lo;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (we) begin
      hi <= hi_in;
      lo <= lo_in;
    end
  end

  // A read in the commit cycle sees the old pair; the new one appears after the edge.
  always_comb begin
    case (sel)
      SEL_HI:  data_out = hi;
      SEL_LO:  data_out = lo;
      default: data_out = '0;
    endcase
  end

endmodule

// File: rtl/multu_hilo.sv
// 32x32 unsigned shift-and-add multiplier (one bit per cycle) whose 64-bit
// product is committed into the HiLo pair on the OPENHILO command.
module multu_hilo
  import multu_hilo_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Signal,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [1:0]  SelHilo,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        done
);

  state_t      state;
  state_t      state_nxt;
  logic [63:0] product;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [4:0]  count;
  logic        pending;
  logic [5:0]  prev_sig;
  logic        start;
  logic        commit;

  // Only the rising edge of the MULTU command starts a run; holding it does not.
  assign start = (Signal == SIG_MULTU) && (prev_sig != SIG_MULTU);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (count == 5'd31) state_nxt = ST_DONE;
      ST_DONE: begin
        if (start) begin
          state_nxt = ST_RUN;
        end else if ((Signal == SIG_OPENHILO) || pending) begin
          commit    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      product  <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      pending  <= 1'b0;
      prev_sig <= '0;
    end else begin
      prev_sig <= Signal;
      if (start && (state != ST_RUN)) begin
        product <= '0;
        mcand   <= {32'b0, dataA};
        mplier  <= dataB;
        count   <= '0;
        pending <= 1'b0;
      end else if (state == ST_RUN) begin
        if (mplier[0]) product <= product + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 5'd1;
        // An early commit request is remembered and honoured on the first DONE edge.
        if (Signal == SIG_OPENHILO) pending <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  hilo_reg u_hilo (
    .clk      (clk),
    .reset    (reset),
    .we       (commit),
    .hi_in    (product[63:32]),
    .lo_in    (product[31:0]),
    .sel      (SelHilo),
    .data_out (dataOut)
  );

endmodule

// File: tb/tb_multu_hilo.sv
// Randomized self-checking bench for multu_hilo against an arithmetic model
// of the HiLo pair (64-bit product of the last started operands).
module tb_multu_hilo;
  import multu_hilo_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [1:0]  SelHilo;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_hi, exp_lo;
  logic [31:0] cur_a, cur_b;

  multu_hilo dut (
    .clk     (clk),
    .reset   (reset),
    .Signal  (Signal),
    .dataA   (dataA),
    .dataB   (dataB),
    .SelHilo (SelHilo),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hilo(input string tag);
    SelHilo = SEL_HI;
    #1 check({tag, " hi"}, dataOut, exp_hi);
    SelHilo = SEL_LO;
    #1 check({tag, " lo"}, dataOut, exp_lo);
    SelHilo = 2'b00;
  endtask

  task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
    Signal = SIG_MULTU;
    dataA  = a;
    dataB  = b;
    cur_a  = a;
    cur_b  = b;
    tick();
    Signal = 6'd0;
    dataA  = $urandom;
    dataB  = $urandom;
  endtask

  // Bounded wait for done; n is the number of edges taken.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic model_commit();
    logic [63:0] p;
    p = {32'b0, cur_a} * {32'b0, cur_b};
    exp_hi = p[63:32];
    exp_lo = p[31:0];
  endtask

  // Commit with OPENHILO; the read in the commit cycle still shows the old Lo.
  task automatic commit(input string tag);
    Signal  = SIG_OPENHILO;
    SelHilo = SEL_LO;
    #1 check({tag, " old lo in commit cycle"}, dataOut, exp_lo);
    tick();
    Signal = 6'd0;
    model_commit();
    check({tag, " done after commit"}, done, 1'b0);
    check_hilo(tag);
  endtask

  initial begin
    int n;
    reset   = 1'b1;
    Signal  = 6'd0;
    dataA   = '0;
    dataB   = '0;
    SelHilo = 2'b00;
    exp_hi  = '0;
    exp_lo  = '0;
    cur_a   = '0;
    cur_b   = '0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check_hilo("reset");
    SelHilo = 2'b11;
    #1 check("reset sel11", dataOut, 32'h0);
    SelHilo = 2'b00;

    // 3*5 with timing
    start_mul(32'd3, 32'd5);
    check("3x5 busy", busy, 1'b1);
    wait_done(n);
    check("3x5 done latency", n, 32);
    check("3x5 done", done, 1'b1);
    check("3x5 busy end", busy, 1'b0);
    commit("3x5");
    check("3x5 lo=15", exp_lo, 32'd15);

    // max operands
    start_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    commit("max");
    check("max hi const", {exp_hi, exp_lo}, 64'hFFFF_FFFE_0000_0001);

    // pending commit requested at RUN cycle 20
    start_mul(32'h8000_0000, 32'd2);
    repeat (19) tick();
    Signal = SIG_OPENHILO;
    tick();
    Signal = 6'd0;
    check("pend busy", busy, 1'b1);
    wait_done(n);
    check("pend latency", n, 12);
    check("pend done", done, 1'b1);
    tick();
    model_commit();
    check("pend done one cycle", done, 1'b0);
    check_hilo("pend");
    check("pend value", {exp_hi, exp_lo}, 64'h1_0000_0000);

    // MULTU held high: exactly one run, DONE holds, pair unchanged until OPENHILO
    Signal = SIG_MULTU;
    dataA  = 32'd1234;
    dataB  = 32'd5678;
    cur_a  = 32'd1234;
    cur_b  = 32'd5678;
    repeat (40) tick();
    check("held done@40", done, 1'b1);
    repeat (20) tick();
    check("held done@60", done, 1'b1);
    check("held busy@60", busy, 1'b0);
    check_hilo("held prior");
    commit("held");

    // reset mid-run after committing 7
    start_mul(32'd7, 32'd1);
    wait_done(n);
    commit("seven");
    start_mul(32'd9, 32'd9);
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check_hilo("abort");
    start_mul(32'd6, 32'd7);
    wait_done(n);
    check("6x7 latency", n, 32);
    commit("6x7");
    check("6x7 lo=42", exp_lo, 32'd42);

    // zero operands and unused selects
    start_mul(32'd0, $urandom);
    wait_done(n);
    commit("a=0");
    start_mul($urandom, 32'd0);
    wait_done(n);
    commit("b=0");
    SelHilo = 2'b11;
    #1 check("sel11", dataOut, 32'h0);
    SelHilo = 2'b00;
    #1 check("sel00", dataOut, 32'h0);

    // randomized runs: plain commit, early commit, or restart from DONE
    for (int i = 0; i < 16; i++) begin
      int mode;
      int k;
      mode = $urandom_range(0, 2);
      start_mul($urandom, (i % 4 == 0) ? $urandom_range(0, 255) : $urandom);
      if (mode == 1) begin
        k = $urandom_range(1, 25);
        repeat (k) tick();
        Signal = SIG_OPENHILO;
        tick();
        Signal = 6'd0;
        wait_done(n);
        check("rnd pend done", done, 1'b1);
        tick();
        model_commit();
        check("rnd pend idle", done, 1'b0);
        check_hilo("rnd pend");
      end else begin
        wait_done(n);
        check("rnd latency", n, 32);
        if (mode == 2) begin
          start_mul($urandom, $urandom);
          check("rnd restart busy", busy, 1'b1);
          check_hilo("rnd discarded");
          wait_done(n);
        end
        commit("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
